// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: delay-slot FSM state encoding and address width.
// Optional branch-likely support is enabled by defining DELAYSLOT_LIKELY_EN.
package cpu_pkg;

   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DS,
      REDIRECT
   } ds_state_t;

endpackage

// File: rtl/ds_capture_reg.sv
// Holds the resolved branch (pc, target, direction, likely) until its delay slot moves to ID.
// The likely flop exists only when DELAYSLOT_LIKELY_EN is defined.
module ds_capture_reg
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic              clear,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              br_taken,
`ifdef DELAYSLOT_LIKELY_EN
   input  logic              br_likely,
   output logic              cap_likely,
`endif
   output logic [ADDR_W-1:0] cap_pc,
   output logic [ADDR_W-1:0] cap_target,
   output logic              cap_taken
);

   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         cap_pc     <= '0;
         cap_target <= '0;
         cap_taken  <= 1'b0;
`ifdef DELAYSLOT_LIKELY_EN
         cap_likely <= 1'b0;
`endif
      end else if (load) begin
         cap_pc     <= br_pc;
         cap_target <= br_target;
         cap_taken  <= br_taken;
`ifdef DELAYSLOT_LIKELY_EN
         cap_likely <= br_likely;
`endif
      end
   end

endmodule

// File: rtl/delayslot_ctrl.sv
// Branch delay-slot tracker: tags the slot instruction in ID and issues the fetch redirect after it.
// Branch-likely annulment is compiled in with DELAYSLOT_LIKELY_EN.
module delayslot_ctrl
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              br_valid,
   input  logic              br_taken,
   input  logic              br_likely,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              if_valid,
   input  logic              id_ready,
   input  logic              flush,
   output logic              ds_flag,
   output logic [ADDR_W-1:0] ds_branch_pc,
   output logic              nullify,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              busy
);

   ds_state_t         state;
   logic              xfer;
   logic              accept_br;
   logic              ds_xfer;
   logic              sel_taken;
   logic [ADDR_W-1:0] sel_pc;
   logic [ADDR_W-1:0] cap_pc;
   logic [ADDR_W-1:0] cap_target;
   logic              cap_taken;
`ifdef DELAYSLOT_LIKELY_EN
   logic              cap_likely;
   logic              sel_likely;
`else
   logic              unused_likely;
   assign unused_likely = br_likely;
`endif

   assign xfer      = if_valid & id_ready;
   assign accept_br = (state == IDLE) & br_valid;
   assign ds_xfer   = xfer & (accept_br | (state == WAIT_DS));

   // A slot moving in the same cycle as its branch uses the live inputs, not the capture.
   assign sel_taken = (state == IDLE) ? br_taken : cap_taken;
   assign sel_pc    = (state == IDLE) ? br_pc    : cap_pc;
`ifdef DELAYSLOT_LIKELY_EN
   assign sel_likely = (state == IDLE) ? br_likely : cap_likely;
`endif

   assign busy           = (state != IDLE);
   assign redirect_valid = (state == REDIRECT) & ~flush;
   assign redirect_pc    = cap_target;

   ds_capture_reg u_capture (
      .clk        (clk),
      .resetn     (resetn),
      .load       (accept_br & ~flush),
      .clear      (flush),
      .br_pc      (br_pc),
      .br_target  (br_target),
      .br_taken   (br_taken),
`ifdef DELAYSLOT_LIKELY_EN
      .br_likely  (br_likely),
      .cap_likely (cap_likely),
`endif
      .cap_pc     (cap_pc),
      .cap_target (cap_target),
      .cap_taken  (cap_taken)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         ds_flag      <= 1'b0;
         ds_branch_pc <= '0;
`ifdef DELAYSLOT_LIKELY_EN
         nullify      <= 1'b0;
`endif
      end else if (flush) begin
         state   <= IDLE;
         ds_flag <= 1'b0;
`ifdef DELAYSLOT_LIKELY_EN
         nullify <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE:     if (br_valid) state <= !xfer ? WAIT_DS : (br_taken ? REDIRECT : IDLE);
            WAIT_DS:  if (xfer) state <= cap_taken ? REDIRECT : IDLE;
            REDIRECT: state <= IDLE;
            default:  state <= IDLE;
         endcase
         if (xfer) begin
            ds_flag <= ds_xfer;
`ifdef DELAYSLOT_LIKELY_EN
            nullify <= ds_xfer & sel_likely & ~sel_taken;
`endif
            if (ds_xfer) ds_branch_pc <= sel_pc;
         end
      end
   end

`ifndef DELAYSLOT_LIKELY_EN
   assign nullify = 1'b0;
`endif

endmodule

// File: tb/tb_delayslot_ctrl.sv
// Scenario bench for delayslot_ctrl: per-cycle expected outputs go through a scoreboard queue.
// Expected nullify follows DELAYSLOT_LIKELY_EN.
module tb_delayslot_ctrl;
   import cpu_pkg::*;

`ifdef DELAYSLOT_LIKELY_EN
   localparam logic LK = 1'b1;
`else
   localparam logic LK = 1'b0;
`endif

   logic              clk;
   logic              resetn;
   logic              br_valid, br_taken, br_likely;
   logic [ADDR_W-1:0] br_pc, br_target;
   logic              if_valid, id_ready, flush;
   logic              ds_flag, nullify, redirect_valid, busy;
   logic [ADDR_W-1:0] ds_branch_pc, redirect_pc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic              rn, bv, bt, bl, fl, iv, ir;
      logic [ADDR_W-1:0] pc, tgt;
      logic [67:0]       exp;
   } row_t;

   typedef struct {
      string       tag;
      logic [67:0] v;
   } sb_t;

   sb_t exp_q[$];

   delayslot_ctrl dut (
      .clk            (clk),
      .resetn         (resetn),
      .br_valid       (br_valid),
      .br_taken       (br_taken),
      .br_likely      (br_likely),
      .br_pc          (br_pc),
      .br_target      (br_target),
      .if_valid       (if_valid),
      .id_ready       (id_ready),
      .flush          (flush),
      .ds_flag        (ds_flag),
      .ds_branch_pc   (ds_branch_pc),
      .nullify        (nullify),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected word layout: {busy, ds_flag, nullify, redirect_valid, ds_branch_pc, redirect_pc}
   function automatic row_t mk(logic rn, logic bv, logic bt, logic bl, logic fl, logic iv, logic ir,
                               logic [31:0] pc, logic [31:0] tgt,
                               logic e_busy, logic e_ds, logic e_nul, logic e_rv,
                               logic [31:0] e_dspc, logic [31:0] e_rpc);
      row_t r;
      r.rn = rn; r.bv = bv; r.bt = bt; r.bl = bl; r.fl = fl; r.iv = iv; r.ir = ir;
      r.pc = pc; r.tgt = tgt;
      r.exp = {e_busy, e_ds, e_nul, e_rv, e_dspc, e_rpc};
      return r;
   endfunction

   function automatic logic [67:0] observed();
      return {busy, ds_flag, nullify, redirect_valid, ds_branch_pc, redirect_pc};
   endfunction

   task automatic drive(input row_t r);
      resetn = r.rn; br_valid = r.bv; br_taken = r.bt; br_likely = r.bl;
      flush = r.fl; if_valid = r.iv; id_ready = r.ir;
      br_pc = r.pc; br_target = r.tgt;
   endtask

   task automatic push_exp(input string tag, input logic [67:0] v);
      sb_t s;
      s.tag = tag;
      s.v   = v;
      exp_q.push_back(s);
   endtask

   task automatic test_reset();
      row_t rows[$];
      sb_t e;
      logic [67:0] a;
      rows.push_back(mk(0,1,1,1,0,1,1, 32'h1111_0000, 32'h2222_0000, 0,0,0,0, '0, '0));
      rows.push_back(mk(0,0,0,0,0,0,0, '0, '0,                       0,0,0,0, '0, '0));
      foreach (rows[i]) begin
         drive(rows[i]);
         push_exp("reset", rows[i].exp);
         @(posedge clk); #1;
         a = observed(); e = exp_q.pop_front();
         checks++;
         if (a !== e.v) begin
            errors++;
            $display("FAIL %s[%0d] got busy/ds/nul/rv=%b dspc=%h rpc=%h want %b %h %h",
                     e.tag, i, a[67:64], a[63:32], a[31:0], e.v[67:64], e.v[63:32], e.v[31:0]);
         end
      end
   endtask

   task automatic test_taken_same_cycle();
      row_t rows[$];
      sb_t e;
      logic [67:0] a;
      rows.push_back(mk(1,1,1,0,0,1,1, 32'hBFC0_0100, 32'hBFC0_0200, 1,1,0,1, 32'hBFC0_0100, 32'hBFC0_0200));
      rows.push_back(mk(1,0,0,0,0,1,1, '0, '0,                       0,0,0,0, 32'hBFC0_0100, 32'hBFC0_0200));
      foreach (rows[i]) begin
         drive(rows[i]);
         push_exp("taken_same", rows[i].exp);
         @(posedge clk); #1;
         a = observed(); e = exp_q.pop_front();
         checks++;
         if (a !== e.v) begin
            errors++;
            $display("FAIL %s[%0d] got busy/ds/nul/rv=%b dspc=%h rpc=%h want %b %h %h",
                     e.tag, i, a[67:64], a[63:32], a[31:0], e.v[67:64], e.v[63:32], e.v[31:0]);
         end
      end
   endtask

   task automatic test_wait_ds();
      row_t rows[$];
      sb_t e;
      logic [67:0] a;
      rows.push_back(mk(1,1,1,0,0,0,1, 32'hBFC0_0300, 32'hBFC0_0400, 1,0,0,0, 32'hBFC0_0100, 32'hBFC0_0400));
      // a second branch while busy must not disturb the captured one
      rows.push_back(mk(1,1,0,1,0,0,1, 32'hDEAD_BEEF, 32'h1234_5678, 1,0,0,0, 32'hBFC0_0100, 32'hBFC0_0400));
      rows.push_back(mk(1,0,0,0,0,1,0, '0, '0,                       1,0,0,0, 32'hBFC0_0100, 32'hBFC0_0400));
      rows.push_back(mk(1,0,0,0,0,1,1, '0, '0,                       1,1,0,1, 32'hBFC0_0300, 32'hBFC0_0400));
      rows.push_back(mk(1,0,0,0,0,0,1, '0, '0,                       0,1,0,0, 32'hBFC0_0300, 32'hBFC0_0400));
      foreach (rows[i]) begin
         drive(rows[i]);
         push_exp("wait_ds", rows[i].exp);
         @(posedge clk); #1;
         a = observed(); e = exp_q.pop_front();
         checks++;
         if (a !== e.v) begin
            errors++;
            $display("FAIL %s[%0d] got busy/ds/nul/rv=%b dspc=%h rpc=%h want %b %h %h",
                     e.tag, i, a[67:64], a[63:32], a[31:0], e.v[67:64], e.v[63:32], e.v[31:0]);
         end
      end
   endtask

   task automatic test_not_taken();
      row_t rows[$];
      sb_t e;
      logic [67:0] a;
      rows.push_back(mk(1,1,0,0,0,0,1, 32'h8000_0010, 32'h8000_0100, 1,1,0,0, 32'hBFC0_0300, 32'h8000_0100));
      rows.push_back(mk(1,0,0,0,0,1,1, '0, '0,                       0,1,0,0, 32'h8000_0010, 32'h8000_0100));
      rows.push_back(mk(1,0,0,0,0,1,1, '0, '0,                       0,0,0,0, 32'h8000_0010, 32'h8000_0100));
      foreach (rows[i]) begin
         drive(rows[i]);
         push_exp("not_taken", rows[i].exp);
         @(posedge clk); #1;
         a = observed(); e = exp_q.pop_front();
         checks++;
         if (a !== e.v) begin
            errors++;
            $display("FAIL %s[%0d] got busy/ds/nul/rv=%b dspc=%h rpc=%h want %b %h %h",
                     e.tag, i, a[67:64], a[63:32], a[31:0], e.v[67:64], e.v[63:32], e.v[31:0]);
         end
      end
   endtask

   task automatic test_flush();
      row_t rows[$];
      sb_t e;
      logic [67:0] a;
      rows.push_back(mk(1,1,1,0,0,0,1, 32'hA000_0040, 32'hA000_0080, 1,0,0,0, 32'h8000_0010, 32'hA000_0080));
      rows.push_back(mk(1,0,0,0,1,1,1, '0, '0,                       0,0,0,0, 32'h8000_0010, '0));
      rows.push_back(mk(1,0,0,0,0,1,1, '0, '0,                       0,0,0,0, 32'h8000_0010, '0));
      rows.push_back(mk(1,1,1,0,0,1,1, 32'h0040_0000, 32'h0040_0100, 1,1,0,1, 32'h0040_0000, 32'h0040_0100));
      foreach (rows[i]) begin
         drive(rows[i]);
         push_exp("flush", rows[i].exp);
         @(posedge clk); #1;
         a = observed(); e = exp_q.pop_front();
         checks++;
         if (a !== e.v) begin
            errors++;
            $display("FAIL %s[%0d] got busy/ds/nul/rv=%b dspc=%h rpc=%h want %b %h %h",
                     e.tag, i, a[67:64], a[63:32], a[31:0], e.v[67:64], e.v[63:32], e.v[31:0]);
         end
      end
      // now in REDIRECT: a flush must gate the pulse within the same cycle
      drive(mk(1,0,0,0,1,1,1, '0, '0, 0,0,0,0, '0, '0));
      #1;
      checks++;
      if (redirect_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_gates_redirect got %b want 0", redirect_valid);
      end
      push_exp("flush_redirect", {1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 32'h0});
      @(posedge clk); #1;
      a = observed(); e = exp_q.pop_front();
      checks++;
      if (a !== e.v) begin
         errors++;
         $display("FAIL %s got busy/ds/nul/rv=%b dspc=%h rpc=%h want %b %h %h",
                  e.tag, a[67:64], a[63:32], a[31:0], e.v[67:64], e.v[63:32], e.v[31:0]);
      end
   endtask

   task automatic test_likely();
      row_t rows[$];
      sb_t e;
      logic [67:0] a;
      rows.push_back(mk(1,1,0,1,0,1,1, 32'h9FC0_0000, 32'h9FC0_0010, 0,1,LK,0, 32'h9FC0_0000, 32'h9FC0_0010));
      rows.push_back(mk(1,0,0,0,0,1,1, '0, '0,                       0,0,0,0,  32'h9FC0_0000, 32'h9FC0_0010));
      rows.push_back(mk(1,1,0,1,0,0,1, 32'h9FC0_0020, 32'h9FC0_0030, 1,0,0,0,  32'h9FC0_0000, 32'h9FC0_0030));
      rows.push_back(mk(1,0,0,0,0,1,1, '0, '0,                       0,1,LK,0, 32'h9FC0_0020, 32'h9FC0_0030));
      rows.push_back(mk(1,0,0,0,0,1,1, '0, '0,                       0,0,0,0,  32'h9FC0_0020, 32'h9FC0_0030));
      foreach (rows[i]) begin
         drive(rows[i]);
         push_exp("likely", rows[i].exp);
         @(posedge clk); #1;
         a = observed(); e = exp_q.pop_front();
         checks++;
         if (a !== e.v) begin
            errors++;
            $display("FAIL %s[%0d] got busy/ds/nul/rv=%b dspc=%h rpc=%h want %b %h %h",
                     e.tag, i, a[67:64], a[63:32], a[31:0], e.v[67:64], e.v[63:32], e.v[31:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      row_t rows[$];
      sb_t e;
      logic [67:0] a;
      rows.push_back(mk(1,1,1,0,0,1,1, 32'hC000_0000, 32'hC000_0100, 1,1,0,1, 32'hC000_0000, 32'hC000_0100));
      rows.push_back(mk(1,1,1,0,0,1,1, 32'hD000_0000, 32'hD000_0100, 0,0,0,0, 32'hC000_0000, 32'hC000_0100));
      rows.push_back(mk(1,1,1,0,0,1,1, 32'hD000_0000, 32'hD000_0100, 1,1,0,1, 32'hD000_0000, 32'hD000_0100));
      rows.push_back(mk(1,0,0,0,0,0,1, '0, '0,                       0,1,0,0, 32'hD000_0000, 32'hD000_0100));
      foreach (rows[i]) begin
         drive(rows[i]);
         push_exp("back_to_back", rows[i].exp);
         @(posedge clk); #1;
         a = observed(); e = exp_q.pop_front();
         checks++;
         if (a !== e.v) begin
            errors++;
            $display("FAIL %s[%0d] got busy/ds/nul/rv=%b dspc=%h rpc=%h want %b %h %h",
                     e.tag, i, a[67:64], a[63:32], a[31:0], e.v[67:64], e.v[63:32], e.v[31:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      row_t rows[$];
      sb_t e;
      logic [67:0] a;
      rows.push_back(mk(1,1,1,0,0,0,1, 32'hB000_0000, 32'hB000_0100, 1,1,0,0, 32'hD000_0000, 32'hB000_0100));
      rows.push_back(mk(0,0,0,0,0,1,1, '0, '0,                       0,0,0,0, '0, '0));
      rows.push_back(mk(1,0,0,0,0,1,1, '0, '0,                       0,0,0,0, '0, '0));
      rows.push_back(mk(1,0,0,0,0,0,1, '0, '0,                       0,0,0,0, '0, '0));
      foreach (rows[i]) begin
         drive(rows[i]);
         push_exp("reset_mid", rows[i].exp);
         @(posedge clk); #1;
         a = observed(); e = exp_q.pop_front();
         checks++;
         if (a !== e.v) begin
            errors++;
            $display("FAIL %s[%0d] got busy/ds/nul/rv=%b dspc=%h rpc=%h want %b %h %h",
                     e.tag, i, a[67:64], a[63:32], a[31:0], e.v[67:64], e.v[63:32], e.v[31:0]);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_taken_same_cycle();
      test_wait_ds();
      test_not_taken();
      test_flush();
      test_likely();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
